// File: rtl/decoder_3to8_seq_if.sv
// rtl/decoder_3to8_seq_if.sv - handshake/status bundle for decoder_3to8_seq
// par exists only when DECODER_PARITY_EN is defined.
interface decoder_3to8_seq_if;
  logic        E;
  logic [2:0]  A;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  Y;
  logic        y_valid;
  logic        busy;
  logic [15:0] count;
  logic        err;
`ifdef DECODER_PARITY_EN
  logic        par;
`endif

  modport master (
`ifdef DECODER_PARITY_EN
    output par,
`endif
    output E, A, in_valid,
    input  in_ready, Y, y_valid, busy, count, err
  );

  modport slave (
`ifdef DECODER_PARITY_EN
    input  par,
`endif
    input  E, A, in_valid,
    output in_ready, Y, y_valid, busy, count, err
  );
endinterface

// File: rtl/decoder_3to8_seq.sv
// rtl/decoder_3to8_seq.sv - sequenced 3-to-8 decoder: hold one-hot output, then idle gap
// Optional even-parity check on A enabled by DECODER_PARITY_EN.
module decoder_3to8_seq #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input logic               clk,
  input logic               rst_n,
  decoder_3to8_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

  // HOLD_CYCLES of 0 is treated as 1, so both load a zero counter.
  localparam logic [7:0] HOLD_LOAD = (HOLD_CYCLES <= 1) ? 8'd0 : 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GAP_LOAD  = (GAP_CYCLES  <= 1) ? 8'd0 : 8'(GAP_CYCLES - 1);
  localparam bit         HAS_GAP   = (GAP_CYCLES > 0);

  state_t      state;
  logic [7:0]  hold_cnt;
  logic [7:0]  gap_cnt;
  logic [7:0]  y_q;
  logic        y_valid_q;
  logic [15:0] cnt_q;
  logic        accept;
  logic        parity_ok;

  assign bus.in_ready = rst_n && bus.E && (state == IDLE);
  assign accept       = bus.in_valid && bus.in_ready;

`ifdef DECODER_PARITY_EN
  logic err_q;
  assign parity_ok = ~^{bus.A, bus.par};
  assign bus.err   = err_q;
`else
  assign parity_ok = 1'b1;
  assign bus.err   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold_cnt  <= 8'd0;
      gap_cnt   <= 8'd0;
      y_q       <= 8'd0;
      y_valid_q <= 1'b0;
      cnt_q     <= 16'd0;
`ifdef DECODER_PARITY_EN
      err_q     <= 1'b0;
`endif
    end else begin
`ifdef DECODER_PARITY_EN
      err_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (accept) begin
            if (parity_ok) begin
              y_q       <= 8'd1 << bus.A;
              y_valid_q <= 1'b1;
              hold_cnt  <= HOLD_LOAD;
              cnt_q     <= cnt_q + 16'd1;
              state     <= HOLD;
            end else begin
`ifdef DECODER_PARITY_EN
              // Handshake completes but the code is dropped.
              err_q <= 1'b1;
`endif
            end
          end
        end
        HOLD: begin
          if (!bus.E) begin
            y_q       <= 8'd0;
            y_valid_q <= 1'b0;
            state     <= IDLE;
          end else if (hold_cnt == 8'd0) begin
            y_q       <= 8'd0;
            y_valid_q <= 1'b0;
            if (HAS_GAP) begin
              gap_cnt <= GAP_LOAD;
              state   <= GAP;
            end else begin
              state   <= IDLE;
            end
          end else begin
            hold_cnt <= hold_cnt - 8'd1;
          end
        end
        GAP: begin
          if (!bus.E || gap_cnt == 8'd0) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        default: begin
          state     <= IDLE;
          y_q       <= 8'd0;
          y_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Y       = y_q;
  assign bus.y_valid = y_valid_q;
  assign bus.busy    = (state != IDLE);
  assign bus.count   = cnt_q;

endmodule

// File: tb/tb_decoder_3to8_seq.sv
// tb/tb_decoder_3to8_seq.sv - directed self-checking bench for decoder_3to8_seq
// Parity scenario runs only when DECODER_PARITY_EN is defined.
module tb_decoder_3to8_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  decoder_3to8_seq_if ifc ();
  decoder_3to8_seq_if ifc2 ();

  decoder_3to8_seq #(.HOLD_CYCLES(4), .GAP_CYCLES(1)) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc)
  );

  // HOLD_CYCLES=0 must act as 1; GAP_CYCLES=0 gives back-to-back accepts.
  decoder_3to8_seq #(.HOLD_CYCLES(0), .GAP_CYCLES(0)) u_b2b (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ifc.in_valid = 1'b0;
    ifc2.in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    ifc.E = 1'b1;
    ifc.A = 3'd0;
    ifc.in_valid = 1'b0;
    ifc2.E = 1'b1;
    ifc2.A = 3'd0;
    ifc2.in_valid = 1'b0;
`ifdef DECODER_PARITY_EN
    ifc.par = 1'b0;
    ifc2.par = 1'b0;
`endif
    rst_n = 1'b0;
    tick();
    tick();
    total++; if (ifc.Y !== 8'h00) begin bad++; $display("FAIL reset_y: got %0h expected 0", ifc.Y); end
    total++; if (ifc.y_valid !== 1'b0) begin bad++; $display("FAIL reset_yv: got %0b expected 0", ifc.y_valid); end
    total++; if (ifc.count !== 16'h0000) begin bad++; $display("FAIL reset_count: got %0h expected 0", ifc.count); end
    total++; if (ifc.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b expected 0", ifc.busy); end
    total++; if (ifc.err !== 1'b0) begin bad++; $display("FAIL reset_err: got %0b expected 0", ifc.err); end
    total++; if (ifc.in_ready !== 1'b0) begin bad++; $display("FAIL reset_rdy_low: got %0b expected 0", ifc.in_ready); end
    rst_n = 1'b1;
    #1;
    total++; if (ifc.in_ready !== 1'b1) begin bad++; $display("FAIL reset_rdy_rel: got %0b expected 1", ifc.in_ready); end
  endtask

  task automatic test_single();
    ifc.E = 1'b1;
    ifc.A = 3'd5;
    ifc.in_valid = 1'b1;
    tick();
    ifc.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++; if (ifc.Y !== 8'b00100000 || ifc.y_valid !== 1'b1) begin bad++; $display("FAIL single_hold%0d: got %0h/%0b expected 20/1", i, ifc.Y, ifc.y_valid); end
      total++; if (ifc.in_ready !== 1'b0 || ifc.busy !== 1'b1) begin bad++; $display("FAIL single_rdy%0d: got rdy=%0b busy=%0b expected 0/1", i, ifc.in_ready, ifc.busy); end
      tick();
    end
    total++; if (ifc.Y !== 8'h00 || ifc.y_valid !== 1'b0 || ifc.in_ready !== 1'b0 || ifc.busy !== 1'b1) begin
      bad++; $display("FAIL single_gap: got y=%0h yv=%0b rdy=%0b busy=%0b expected 0/0/0/1", ifc.Y, ifc.y_valid, ifc.in_ready, ifc.busy); end
    tick();
    total++; if (ifc.in_ready !== 1'b1 || ifc.busy !== 1'b0) begin bad++; $display("FAIL single_idle: got rdy=%0b busy=%0b expected 1/0", ifc.in_ready, ifc.busy); end
    total++; if (ifc.count !== 16'd1) begin bad++; $display("FAIL single_count: got %0d expected 1", ifc.count); end
  endtask

  task automatic test_sweep();
    int waits;
    do_reset();
    ifc.E = 1'b1;
    ifc.in_valid = 1'b1;
    for (int a = 0; a < 8; a++) begin
      ifc.A = 3'(a);
      waits = 0;
      while (ifc.in_ready !== 1'b1 && waits < 20) begin
        tick();
        waits++;
      end
      total++; if (waits >= 20) begin bad++; $display("FAIL sweep_timeout%0d: waited %0d cycles, limit 20", a, waits); end
      // Previous code occupies HOLD(4)+GAP(1) cycles before ready returns.
      if (a > 0) begin
        total++; if (waits != 5) begin bad++; $display("FAIL sweep_busy_cycles%0d: got %0d expected 5", a, waits); end
      end
      tick();
      total++; if (ifc.Y !== (8'd1 << a) || ifc.y_valid !== 1'b1) begin bad++; $display("FAIL sweep_y%0d: got %0h expected %0h", a, ifc.Y, 8'd1 << a); end
      total++; if (ifc.in_ready !== 1'b0) begin bad++; $display("FAIL sweep_rdy%0d: got %0b expected 0", a, ifc.in_ready); end
    end
    ifc.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    total++; if (ifc.count !== 16'd8 || ifc.busy !== 1'b0) begin bad++; $display("FAIL sweep_count: got %0d busy=%0b expected 8/0", ifc.count, ifc.busy); end
  endtask

  task automatic test_abort();
    do_reset();
    ifc.E = 1'b1;
    ifc.A = 3'd2;
    ifc.in_valid = 1'b1;
    tick();
    ifc.in_valid = 1'b0;
    tick();
    total++; if (ifc.Y !== 8'b00000100) begin bad++; $display("FAIL abort_pre: got %0h expected 04", ifc.Y); end
    ifc.E = 1'b0;
    tick();
    total++; if (ifc.Y !== 8'h00 || ifc.y_valid !== 1'b0 || ifc.busy !== 1'b0) begin bad++; $display("FAIL abort_y: got y=%0h yv=%0b busy=%0b expected 0/0/0", ifc.Y, ifc.y_valid, ifc.busy); end
    total++; if (ifc.count !== 16'd1) begin bad++; $display("FAIL abort_count: got %0d expected 1", ifc.count); end
    ifc.in_valid = 1'b1;
    tick();
    tick();
    total++; if (ifc.in_ready !== 1'b0 || ifc.Y !== 8'h00 || ifc.count !== 16'd1) begin bad++; $display("FAIL disabled_idle: got rdy=%0b y=%0h cnt=%0d expected 0/0/1", ifc.in_ready, ifc.Y, ifc.count); end
    ifc.in_valid = 1'b0;
    ifc.E = 1'b1;
    #1;
    total++; if (ifc.in_ready !== 1'b1) begin bad++; $display("FAIL abort_rdy: got %0b expected 1", ifc.in_ready); end
  endtask

  task automatic test_wrap();
    force u_dut.cnt_q = 16'hFFFF;
    #1;
    release u_dut.cnt_q;
    ifc.E = 1'b1;
    ifc.A = 3'd0;
    ifc.in_valid = 1'b1;
    tick();
    ifc.in_valid = 1'b0;
    total++; if (ifc.count !== 16'h0000) begin bad++; $display("FAIL wrap_count: got %0h expected 0000", ifc.count); end
    total++; if (ifc.Y !== 8'b00000001) begin bad++; $display("FAIL wrap_y: got %0h expected 01", ifc.Y); end
    for (int i = 0; i < 5; i++) tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    ifc2.E = 1'b1;
    ifc2.A = 3'd3;
    ifc2.in_valid = 1'b1;
    tick();
    ifc2.A = 3'd6;
    total++; if (ifc2.Y !== 8'b00001000 || ifc2.in_ready !== 1'b0) begin bad++; $display("FAIL b2b_first: got y=%0h rdy=%0b expected 08/0", ifc2.Y, ifc2.in_ready); end
    tick();
    total++; if (ifc2.Y !== 8'h00 || ifc2.y_valid !== 1'b0 || ifc2.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_idle: got y=%0h yv=%0b rdy=%0b expected 0/0/1", ifc2.Y, ifc2.y_valid, ifc2.in_ready); end
    tick();
    ifc2.in_valid = 1'b0;
    total++; if (ifc2.Y !== 8'b01000000 || ifc2.count !== 16'd2) begin bad++; $display("FAIL b2b_second: got y=%0h cnt=%0d expected 40/2", ifc2.Y, ifc2.count); end
    tick();
  endtask

  task automatic test_parity();
`ifdef DECODER_PARITY_EN
    do_reset();
    ifc.E = 1'b1;
    ifc.A = 3'd1;
    ifc.par = 1'b0;
    ifc.in_valid = 1'b1;
    tick();
    ifc.in_valid = 1'b0;
    total++; if (ifc.err !== 1'b1 || ifc.Y !== 8'h00 || ifc.y_valid !== 1'b0) begin bad++; $display("FAIL par_err: got err=%0b y=%0h yv=%0b expected 1/0/0", ifc.err, ifc.Y, ifc.y_valid); end
    total++; if (ifc.count !== 16'd0 || ifc.busy !== 1'b0) begin bad++; $display("FAIL par_state: got cnt=%0d busy=%0b expected 0/0", ifc.count, ifc.busy); end
    ifc.par = 1'b1;
    ifc.in_valid = 1'b1;
    tick();
    ifc.in_valid = 1'b0;
    total++; if (ifc.err !== 1'b0 || ifc.Y !== 8'b00000010) begin bad++; $display("FAIL par_ok: got err=%0b y=%0h expected 0/02", ifc.err, ifc.Y); end
    for (int i = 0; i < 5; i++) tick();
`else
    ifc.E = 1'b1;
    ifc.A = 3'd1;
    ifc.in_valid = 1'b1;
    tick();
    ifc.in_valid = 1'b0;
    total++; if (ifc.err !== 1'b0 || ifc.Y !== 8'b00000010) begin bad++; $display("FAIL nopar: got err=%0b y=%0h expected 0/02", ifc.err, ifc.Y); end
    for (int i = 0; i < 5; i++) tick();
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    ifc.E = 1'b1;
    ifc.A = 3'd7;
    ifc.in_valid = 1'b1;
    tick();
    ifc.in_valid = 1'b0;
    tick();
    total++; if (ifc.Y !== 8'b10000000) begin bad++; $display("FAIL rmid_pre: got %0h expected 80", ifc.Y); end
    rst_n = 1'b0;
    tick();
    total++; if (ifc.Y !== 8'h00 || ifc.y_valid !== 1'b0 || ifc.count !== 16'd0) begin bad++; $display("FAIL rmid_clear: got y=%0h yv=%0b cnt=%0d expected 0/0/0", ifc.Y, ifc.y_valid, ifc.count); end
    total++; if (ifc.in_ready !== 1'b0) begin bad++; $display("FAIL rmid_rdy_low: got %0b expected 0", ifc.in_ready); end
    rst_n = 1'b1;
    #1;
    total++; if (ifc.in_ready !== 1'b1) begin bad++; $display("FAIL rmid_rdy: got %0b expected 1", ifc.in_ready); end
    tick();
    total++; if (ifc.Y !== 8'h00 || ifc.busy !== 1'b0) begin bad++; $display("FAIL rmid_after: got y=%0h busy=%0b expected 0/0", ifc.Y, ifc.busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_sweep();
    test_abort();
    test_wrap();
    test_back_to_back();
    test_parity();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decoder_3to8_seq.md
DECODER_3TO8_SEQ -- requirements
Module: decoder_3to8_seq

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 4, cycles the one-hot output is held per code (legal 1..255).
REQ-002 SHALL have parameter GAP_CYCLES, default 1, idle cycles forced after each hold (legal 0..255).
REQ-003 SHALL have port clk, input, 1, sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port E, input, 1, block enable.
REQ-006 SHALL have port A, input, 3, binary code to decode.
REQ-007 SHALL have port in_valid, input, 1, A is valid this cycle.
REQ-008 SHALL have port in_ready, output, 1, block can accept a code this cycle.
REQ-009 SHALL have port Y, output, 8, registered one-hot decode.
REQ-010 SHALL have port y_valid, output, 1, Y holds a decoded code.
REQ-011 SHALL have port busy, output, 1, state is not IDLE.
REQ-012 SHALL have port count, output, 16, number of codes decoded since reset.
REQ-013 SHALL have port err, output, 1, parity error pulse (see Configuration).

Function
REQ-014 SHALL implement states IDLE, HOLD, GAP.
REQ-015 in_ready SHALL equal (state==IDLE && E), combinationally.
REQ-016 Acceptance SHALL occur on a rising edge where in_valid && in_ready.
REQ-017 On acceptance: next cycle Y = 8'b1 << A, y_valid=1, state=HOLD, hold counter = HOLD_CYCLES-1 (one-cycle latency).
REQ-018 Mapping SHALL be A=0 -> 8'b00000001 ... A=7 -> 8'b10000000; exactly one Y bit set while y_valid=1.
REQ-019 In HOLD, Y and y_valid SHALL stay constant for exactly HOLD_CYCLES cycles; counter decrements each cycle.
REQ-020 When the hold counter is 0 in HOLD: next cycle Y=0, y_valid=0; state=GAP with gap counter GAP_CYCLES-1 if GAP_CYCLES>0, else IDLE.
REQ-021 In GAP, Y=0, y_valid=0, in_ready=0 for exactly GAP_CYCLES cycles, then IDLE.
REQ-022 HOLD_CYCLES=0 SHALL behave as HOLD_CYCLES=1.
REQ-023 E=0 in IDLE: in_ready=0, in_valid ignored, no state change.
REQ-024 E=0 in HOLD or GAP: abort; next cycle Y=0, y_valid=0, state=IDLE; count unchanged by the abort.
REQ-025 count SHALL increment by 1 on each successful acceptance, wrapping 16'hFFFF -> 16'h0000.
REQ-026 in_valid while in_ready=0 SHALL be ignored; no code is queued.
REQ-027 Back-to-back: with GAP_CYCLES=0, a new code is accepted on the first IDLE cycle after HOLD ends.

Reset
REQ-028 rst_n=0 at a rising edge SHALL force state=IDLE, Y=0, y_valid=0, count=0, err=0, counters=0, overriding any other event.
REQ-029 Reset asserted mid-HOLD SHALL clear Y on the same edge; no further hold cycles are produced.
REQ-030 While rst_n=0, in_ready SHALL be 0.

Configuration
REQ-031 Macro DECODER_PARITY_EN SHALL, when defined, add port par, input, 1, even parity such that ^{A,par}==0.
REQ-032 With DECODER_PARITY_EN, an accepted code with ^{A,par}==1 SHALL complete the handshake, pulse err=1 for one cycle, leave Y=0, y_valid=0, state IDLE, count unchanged.
REQ-033 Without DECODER_PARITY_EN, port par SHALL be absent and err SHALL be constant 0.

Verification
REQ-034 Reset, E=1, A=3'd5 valid one cycle, HOLD=4, GAP=1 -> Y=8'b00100000 for 4 cycles starting next cycle, then 1 GAP cycle, count=1.
REQ-035 Sweep A=0..7 back-to-back with in_valid held 1 -> each Y one-hot matches 1<<A, in_ready low during HOLD/GAP, count=8.
REQ-036 Drop E during 2nd HOLD cycle of A=3'd2 -> Y=0 next cycle, state IDLE, count still 1.
REQ-037 Preload 65535 accepts (or force count) then one more -> count=16'h0000.
REQ-038 DECODER_PARITY_EN, A=3'd1, par=0 -> err=1 one cycle, Y stays 0, count unchanged; par=1 -> Y=8'b00000010.
REQ-039 rst_n=0 in mid-HOLD of A=3'd7 -> Y=0, y_valid=0, count=0 on that edge; in_ready=1 first cycle after release with E=1.
